// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Purpose
//   Pipelined adder/subtractor built from 4-bit carry-lookahead groups. The
//   WIDTH-bit operands are split into STAGES equal segments of SEG bits. Each
//   pipeline stage adds one segment, LSB segment first, using the carry that
//   the previous stage registered. The upper operand bits and the lower result
//   bits travel along with each stage, so the full word emerges from the last
//   stage register.
//
//   Result: {cout, sum} = a + (sub ? ~b : b) + (sub ? 1 : cin)
//   For subtraction, cout = 1 means no borrow (a >= b unsigned).
//
//   The pipeline uses a valid/ready handshake. Each stage loads when it is
//   empty or when its content moves downstream in the same cycle, so the
//   pipeline runs at one operation per cycle while out_ready is high and
//   collapses bubbles under backpressure. The latency from accepted input to
//   out_valid is exactly STAGES cycles.
//
// Parameters
//   WIDTH   operand width; must be a multiple of 4*STAGES (default 32)
//   STAGES  number of pipeline register stages, 1..WIDTH/4 (default 2)
//
// Ports
//   clk        clock; all state updates on its rising edge
//   rst        synchronous, active-high reset
//   a, b       operands
//   cin        carry in (ignored when sub = 1)
//   sub        0 = a + b + cin, 1 = a - b
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle
//   sum        result
//   cout       carry out (1 = no borrow for subtraction)
//   out_valid  sum / cout / flags valid
//   out_ready  downstream accepts the result
//   ovf        signed overflow (only with CLA_FLAGS_EN)
//   zero       sum == 0        (only with CLA_FLAGS_EN)
//
// Configuration macro
//   CLA_FLAGS_EN  when defined, adds the ovf and zero outputs, pipelined
//                 together with sum.
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
`ifdef CLA_FLAGS_EN
  output logic             ovf,
  output logic             zero,
`endif
  input  logic             out_ready
);

  localparam int SEG    = WIDTH / STAGES;
  localparam int GROUPS = SEG / 4;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH / 4) || (WIDTH % (4 * STAGES) != 0)) begin : g_bad_params
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES and STAGES in 1..WIDTH/4");
    end
  endgenerate

  // One pipeline stage register. opa/opb hold the full operands (b already
  // inverted for subtraction), so later stages pick their own segment out of
  // them; sum collects result segments as they are produced.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef CLA_FLAGS_EN
    logic             ovf;
    logic             zero;
`endif
  } stage_t;

  stage_t           stage_q [STAGES];  // registered stage contents
  stage_t           src     [STAGES];  // what each stage would load
  stage_t           nxt     [STAGES];  // src with this stage's segment added
  logic [STAGES-1:0] load;              // stage k captures this cycle
  logic [SEG+1:0]    seg_res;           // {carry into MSB, carry out, sum}

  // ---------------------------------------------------------------------------
  // Segment adder built from 4-bit lookahead groups. Inside a group every
  // carry is a flat sum-of-products of the group's p/g terms and the group
  // carry in, so no carry ripples bit to bit. Groups are then chained through
  // their group generate / propagate terms.
  // Returns {carry into the segment MSB, carry out of the segment, sum}.
  // The carry into the MSB only matters for the top segment, where it feeds
  // the signed-overflow flag.
  // ---------------------------------------------------------------------------
  function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c_in);
    logic [SEG-1:0] s;
    logic [3:0]     p;
    logic [3:0]     g;
    logic [3:0]     c;
    logic           grp_g;
    logic           grp_p;
    logic           carry;
    logic           c_msb;
    s     = '0;
    p     = '0;
    g     = '0;
    c     = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    carry = c_in;
    c_msb = 1'b0;
    for (int gi = 0; gi < GROUPS; gi++) begin
      p    = x[gi*4 +: 4] ^ y[gi*4 +: 4];
      g    = x[gi*4 +: 4] & y[gi*4 +: 4];
      c[0] = carry;
      c[1] = g[0] | (p[0] & carry);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
             (p[2] & p[1] & p[0] & carry);
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      s[gi*4 +: 4] = p ^ c;
      c_msb = c[3];
      carry = grp_g | (grp_p & carry);
    end
    return {c_msb, carry, s};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake: walk from the output back to the input. A stage loads when it
  // is empty or when whatever sits below it takes its content this cycle, so
  // in_ready is combinational from out_ready through the whole pipeline.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic downstream;
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    load       = '0;
    downstream = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k]    = !stage_q[k].valid || downstream;
      downstream = load[k];
    end
  end

  assign in_ready = load[0] && !rst;

  // ---------------------------------------------------------------------------
  // Datapath: stage 0 is fed from the ports, stage k from stage k-1. Each
  // stage adds its own segment and forwards everything else untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      src[k] = '0;
      nxt[k] = '0;
    end

    src[0].valid = in_valid;
    src[0].opa   = a;
    src[0].opb   = sub ? ~b : b;
    // Subtraction is a + ~b + 1, so the initial carry is forced high.
    src[0].carry = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = stage_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      seg_res = seg_add(src[k].opa[k*SEG +: SEG], src[k].opb[k*SEG +: SEG],
                        src[k].carry);
      nxt[k]                    = src[k];
      nxt[k].valid              = 1'b1;
      nxt[k].sum[k*SEG +: SEG]  = seg_res[SEG-1:0];
      nxt[k].carry              = seg_res[SEG];
`ifdef CLA_FLAGS_EN
      // Only the values computed in the last stage reach the outputs.
      nxt[k].ovf                = seg_res[SEG] ^ seg_res[SEG+1];
      nxt[k].zero               = (nxt[k].sum == '0);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers. Data fields only change when a valid operation moves in,
  // so idle inputs (in_valid = 0) never disturb state and a stalled output
  // holds its value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data fields are reset along with the valid bits because
      // sum/cout/flags must read zero after reset, not just out_valid.
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          // NOTE: non-blocking assignments let every stage sample the value
          // its upstream neighbour held before this edge, independent of
          // loop order.
          if (src[k].valid) begin
            stage_q[k] <= nxt[k];
          end else begin
            stage_q[k].valid <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].sum;
  assign cout      = stage_q[STAGES-1].carry;
`ifdef CLA_FLAGS_EN
  assign ovf       = stage_q[STAGES-1].ovf;
  assign zero      = stage_q[STAGES-1].zero;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Scoreboard bench for pipelined_cla_adder (WIDTH = 32, STAGES = 2). Every
// accepted operation pushes its expected result, computed with plain signed /
// unsigned integer arithmetic, into a queue; an independent monitor pops and
// compares on each output transfer and checks that a stalled output holds.
// ovf / zero are checked when CLA_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int N_RAND = 10000;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
`ifdef CLA_FLAGS_EN
  logic             ovf;
  logic             zero;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic rand_done;

  pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
`ifdef CLA_FLAGS_EN
    .ovf       (ovf),
    .zero      (zero),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference model: integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s);
    exp_t   e;
    longint ua, ub, us, sa, sbv, ss;
    ua  = longint'({32'b0, x});
    ub  = longint'({32'b0, y});
    sa  = longint'($signed(x));
    sbv = longint'($signed(y));
    if (s) begin
      us     = ua - ub;
      ss     = sa - sbv;
      e.cout = (ua >= ub);
    end else begin
      us     = ua + ub + longint'(c);
      ss     = sa + sbv + longint'(c);
      e.cout = (us >= 64'sh1_0000_0000);
    end
    e.sum  = us[WIDTH-1:0];
    e.ovf  = (ss > SMAX) || (ss < SMIN);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // Present one operation and hold it until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic c, input logic s);
    int waited;
    waited   = 0;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(x, y, c, s));
        break;
      end
      waited++;
      if (waited > 1000) begin
        check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare on every output transfer, check stalls hold the output.
  initial begin
    logic             hold;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_cout;
    exp_t             e;
    hold      = 1'b0;
    hold_sum  = '0;
    hold_cout = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", {63'b0, out_valid}, 64'd1);
          check("stall_sum", {32'b0, sum}, {32'b0, hold_sum});
          check("stall_cout", {63'b0, cout}, {63'b0, hold_cout});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            check("sum", {32'b0, sum}, {32'b0, e.sum});
            check("cout", {63'b0, cout}, {63'b0, e.cout});
`ifdef CLA_FLAGS_EN
            check("ovf", {63'b0, ovf}, {63'b0, e.ovf});
            check("zero", {63'b0, zero}, {63'b0, e.zero});
`endif
          end
        end
        hold      = out_valid && !out_ready;
        hold_sum  = sum;
        hold_cout = cout;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    rst       = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_sum", {32'b0, sum}, 64'd0);
    check("rst_cout", {63'b0, cout}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
`ifdef CLA_FLAGS_EN
    check("rst_ovf", {63'b0, ovf}, 64'd0);
    check("rst_zero", {63'b0, zero}, 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Full carry chain plus latency measurement.
    send(32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("latency", 64'(n), 64'(STAGES));
    @(posedge clk);
    #1;
    drain();

    // Subtraction followed back-to-back by a signed overflow.
    send(32'd5, 32'd7, 1'b1, 1'b1);
    send(32'h7fff_ffff, 32'd1, 1'b0, 1'b0);
    send(32'd9, 32'd9, 1'b0, 1'b1);
    drain();

    // Backpressure: STAGES ops fill the pipe, the next one must wait.
    out_ready = 1'b0;
    for (int i = 1; i <= STAGES + 1; i++) begin
      a        = WIDTH'(i);
      b        = WIDTH'(i);
      cin      = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      if (i <= STAGES) check("bp_accept", {63'b0, in_ready}, 64'd1);
      else             check("bp_full_in_ready", {63'b0, in_ready}, 64'd0);
      if (in_ready) sb.push_back(model(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0));
      if (i <= STAGES) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
    if (in_ready) sb.push_back(model(WIDTH'(STAGES + 1), WIDTH'(STAGES + 1), 1'b0, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Mid-stream reset discards in-flight operations.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      send(WIDTH'(100 * (i + 1)), WIDTH'(i + 1), 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_sum", {32'b0, sum}, 64'd0);
    check("midrst_cout", {63'b0, cout}, 64'd0);
    check("midrst_in_ready", {63'b0, in_ready}, 64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_output", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send(32'd10, 32'd20, 1'b0, 1'b0);
    drain();

    // Random regression with random backpressure and idle cycles.
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            a        = $urandom;
            b        = $urandom;
            cin      = 1'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(pick(), pick(), 1'($urandom), 1'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits. It SHALL be a multiple of 4*STAGES.
REQ-002 Parameter STAGES, default 2: number of pipeline register stages. Legal range is 1..WIDTH/4.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 cin  input  1  carry in; ignored when sub=1.
REQ-008 sub  input  1  operation select: 0 = A+B+cin, 1 = A-B.
REQ-009 in_valid  input  1  operands valid.
REQ-010 in_ready  output  1  block can accept operands this cycle.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry out; for subtraction, 1 = no borrow.
REQ-013 out_valid  output  1  sum, cout and flags are valid.
REQ-014 out_ready  input  1  downstream accepts the result.

Function
REQ-015 The block SHALL compute {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), truncated to WIDTH+1 bits.
REQ-016 Bits SHALL be split into STAGES equal segments of SEG = WIDTH/STAGES bits; stage k SHALL add segment k (LSB first) using the carry registered from stage k-1.
REQ-017 Inside each segment, 4-bit carry-lookahead groups SHALL be used (p=a^b, g=a&b), with group generate/propagate terms forming carries between groups, so there is no ripple through bits within a group.
REQ-018 Operand bits above the current segment and result bits below it SHALL be carried forward in the stage registers, with sub/cin alignment preserved.
REQ-019 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls.
REQ-020 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-021 A transfer SHALL occur on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
REQ-022 Each stage register SHALL load when it is empty or when its downstream stage/output is transferring in the same cycle.
REQ-023 in_ready SHALL be 1 when stage 0 is empty or when stage 0 advances this cycle; it is combinational from out_ready through the pipeline.
REQ-024 While out_valid=1 and out_ready=0, sum, cout and flags SHALL hold stable.
REQ-025 With the pipeline full and out_ready=0, in_ready SHALL be 0 and no operation may be lost or duplicated.
REQ-026 Results SHALL leave in acceptance order.
REQ-027 Inputs presented with in_valid=0 SHALL NOT affect state.
REQ-028 Simultaneous input and output transfers on a full pipeline SHALL both complete in the same cycle.

Reset
REQ-029 While rst=1 at a clk edge, all stage valid bits SHALL clear, and out_valid=0, sum=0, cout=0 (and flags=0 when enabled).
REQ-030 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst is released.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result for them SHALL ever appear.

Configuration
REQ-032 Macro CLA_FLAGS_EN. When defined, the block SHALL add output ports ovf (1 bit: signed overflow, i.e. carry into MSB xor carry out of MSB) and zero (1 bit: sum==0). These SHALL be pipelined with sum and follow REQ-024 and REQ-029.
REQ-033 When CLA_FLAGS_EN is undefined, the ovf and zero ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=32, STAGES=2, CLA_FLAGS_EN defined unless noted)
REQ-034 Reset check: hold rst=1 for 2 cycles -> out_valid=0, sum=0, cout=0, ovf=0, zero=0; in_ready=1 one cycle after release.
REQ-035 Full carry chain: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 2 cycles later sum=0x00000000, cout=1, zero=1, ovf=0.
REQ-036 Subtraction: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=0x7FFFFFFF, b=1, sub=0 on the next cycle -> sum=0x80000000, ovf=1, one cycle later.
REQ-037 Backpressure: out_ready=0, present 3 back-to-back ops (1+1, 2+2, 3+3) -> only 2 accepted, in_ready=0, out sum=2 held stable; then raise out_ready -> results 2, 4, 6 appear in order, with the third accepted the same cycle.
REQ-038 Mid-stream reset: accept 2 ops, assert rst for 1 cycle before any output -> no out_valid for those ops; a new op 10+20 after release -> sum=30 after 2 cycles.
REQ-039 Random regression: 10k random a/b/cin/sub with random out_ready, run with and without CLA_FLAGS_EN and for STAGES=1,2,4 -> every result matches the reference model in order.
